// File: rtl/jt1943_obj_pkg.sv
// Shared constants and types for the 1943 object line buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: transparent colour nibble, blank pixel value, line width,
// buffer state enum and a small opacity helper.
package jt1943_obj_pkg;

  // Colour nibble that marks a see-through object pixel
  localparam logic [3:0] OBJ_TRANSP = 4'hf;
  // Value stored in an empty location and presented when no object is on a pixel
  localparam logic [7:0] OBJ_BLANK  = 8'hff;
  // Pixels held per bank
  localparam int         OBJ_LINE_W = 256;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } objbuf_state_t;

  // True when a colour nibble carries visible data
  function automatic logic is_opaque(input logic [3:0] col, input logic [3:0] transp);
    return col != transp;
  endfunction

endpackage

// File: rtl/jt1943_objbuf_ram.sv
// Single-port 2^AW x DW synchronous RAM, one bank of the object line buffer.
// Latency: read data registered, valid the clk after the address is presented.
// Backpressure: none; a read and a write may share a clk (read returns old data).
//
// Ports:
//   clk     in   clock
//   i_addr  in   AW   address for both read and write
//   i_we    in   1    write enable
//   i_wdat  in   DW   write data
//   o_rdat  out  DW   registered read data
module jt1943_objbuf_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [DW-1:0] i_wdat,
  output logic [DW-1:0] o_rdat
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdat;
    r_rdat <= r_mem[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/jt1943_objbuf_line.sv
// Double-buffered object line buffer: stores line N+1 from the draw stage, plays back line N.
// Latency: obj_pxl presents the pixel addressed by hdump one cen6 slot after hdump is sampled.
// Backpressure: none; one write and one read/clear every 4-clk cen6 slot, busy high during clear sweep.
//
// Ports:
//   clk      in   1    system clock (24 MHz)
//   rst_n    in   1    synchronous reset, active low
//   cen6     in   1    pixel enable, one clk in every 4
//   LHBL     in   1    line blank, active low; falling edge swaps banks
//   posx     in   9    write x; bit 8 set means off-line (no write)
//   pxl_in   in   DW   pixel from the draw stage
//   hdump    in   AW   read x of the line on screen
//   obj_pxl  out  DW   buffered pixel, all ones when no object
//   busy     out  1    high while the post-reset clear sweep runs
//
// Build option: define JT1943_OBJBUF_FIRSTWIN_EN so that the first opaque
// pixel drawn at a location wins; otherwise the last opaque pixel wins.
module jt1943_objbuf_line
  import jt1943_obj_pkg::*;
#(
  parameter int         AW     = 8,
  parameter int         DW     = 8,
  parameter logic [3:0] TRANSP = OBJ_TRANSP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen6,
  input  logic          LHBL,
  input  logic [8:0]    posx,
  input  logic [DW-1:0] pxl_in,
  input  logic [AW-1:0] hdump,
  output logic [DW-1:0] obj_pxl,
  output logic          busy
);

  localparam logic [DW-1:0] BLANK    = {DW{1'b1}};
  localparam logic [AW:0]   CLR_LAST = {1'b0, {AW{1'b1}}};

  objbuf_state_t r_state;
  logic          r_busy;
  logic [AW:0]   r_cnt;
  logic [1:0]    r_ph;
  logic          r_wsel;
  logic          r_lhbl;

  // Slot registers, captured at cen6 and held for the whole 4-clk slot
  logic          r_slot_vld;
  logic [8:0]    r_slot_posx;
  logic [DW-1:0] r_slot_pxl;
  logic [AW-1:0] r_slot_hdump;
  logic          r_slot_wsel;

  logic [DW-1:0] r_rdat;
  logic [DW-1:0] r_obj_pxl;

  logic          w_clr;
  logic          w_ph2;
  logic          w_wr_ok;
  logic [DW-1:0] w_rd_rdat;

  logic [AW-1:0] w_addr [2];
  logic          w_we   [2];
  logic [DW-1:0] w_wdat [2];
  logic [DW-1:0] w_rdat [2];

  // rst_n gates the RAM strobes so a reset landing mid-slot drops the pending write
  assign w_clr = (r_state == CLR) && rst_n;
  assign w_ph2 = (r_state == RUN) && r_slot_vld && (r_ph == 2'd2) && rst_n;

  // The bank not selected for writing is the one on screen
  assign w_rd_rdat = r_slot_wsel ? w_rdat[0] : w_rdat[1];

`ifdef JT1943_OBJBUF_FIRSTWIN_EN
  logic [DW-1:0] w_wr_rdat;
  // Phase-1 read of the write bank: only fill a location that still holds see-through data
  assign w_wr_rdat = r_slot_wsel ? w_rdat[1] : w_rdat[0];
  assign w_wr_ok   = !r_slot_posx[8]
                   && is_opaque(r_slot_pxl[3:0], TRANSP)
                   && !is_opaque(w_wr_rdat[3:0], TRANSP);
`else
  assign w_wr_ok   = !r_slot_posx[8] && is_opaque(r_slot_pxl[3:0], TRANSP);
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic w_is_wr;
    assign w_is_wr = (r_slot_wsel == 1'(b));

    // Write bank follows posx, read bank follows hdump; the clear sweep hits both
    assign w_addr[b] = w_clr   ? r_cnt[AW-1:0] :
                       w_is_wr ? r_slot_posx[AW-1:0] : r_slot_hdump;
    assign w_we[b]   = w_clr || (w_ph2 && (!w_is_wr || w_wr_ok));
    assign w_wdat[b] = (w_clr || !w_is_wr) ? BLANK : r_slot_pxl;

    jt1943_objbuf_ram #(
      .AW (AW),
      .DW (DW)
    ) u_ram (
      .clk    (clk),
      .i_addr (w_addr[b]),
      .i_we   (w_we[b]),
      .i_wdat (w_wdat[b]),
      .o_rdat (w_rdat[b])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= CLR;
      r_busy       <= 1'b1;
      r_cnt        <= '0;
      r_ph         <= 2'd0;
      r_wsel       <= 1'b0;
      r_lhbl       <= 1'b1;
      r_slot_vld   <= 1'b0;
      r_slot_posx  <= '0;
      r_slot_pxl   <= '0;
      r_slot_hdump <= '0;
      r_slot_wsel  <= 1'b0;
      r_rdat       <= BLANK;
      r_obj_pxl    <= BLANK;
    end else begin
      // cen6 marks phase 0, so the clk after it is phase 1
      r_ph <= cen6 ? 2'd1 : r_ph + 2'd1;

      case (r_state)
        CLR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CLR_LAST) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end

        RUN: begin
          if (cen6) begin
            r_lhbl <= LHBL;
            if (r_lhbl && !LHBL) r_wsel <= ~r_wsel;
            // The slot keeps the bank select in force when it starts
            r_slot_vld   <= 1'b1;
            r_slot_posx  <= posx;
            r_slot_pxl   <= pxl_in;
            r_slot_hdump <= hdump;
            r_slot_wsel  <= r_wsel;
            r_obj_pxl    <= r_rdat;
          end
          if (w_ph2) r_rdat <= w_rd_rdat;
        end

        default: r_state <= CLR;
      endcase
    end
  end

  assign obj_pxl = r_obj_pxl;
  assign busy    = r_busy;

endmodule

// File: tb/tb_jt1943_objbuf_line.sv
module tb_jt1943_objbuf_line;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       cen6   = 1'b0;
  logic       LHBL   = 1'b1;
  logic [8:0] posx   = '0;
  logic [7:0] pxl_in = '0;
  logic [7:0] hdump  = '0;
  logic [7:0] obj_pxl;
  logic       busy;

  int    checks = 0;
  int    errors = 0;
  string tag    = "init";

  jt1943_objbuf_line dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen6    (cen6),
    .LHBL    (LHBL),
    .posx    (posx),
    .pxl_in  (pxl_in),
    .hdump   (hdump),
    .obj_pxl (obj_pxl),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Reference: two line memories, a bank select and the last blank level.
  logic [7:0] m_bank [2][256];
  bit         m_wsel;
  bit         m_lh;
  logic [7:0] exp_prev;

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) m_bank[b][a] = 8'hff;
    m_wsel   = 1'b0;
    m_lh     = 1'b1;
    exp_prev = 8'hff;
  endtask

  // One pixel slot: read-and-clear the on-screen line, draw into the other one.
  task automatic model_slot(input logic [8:0] px, input logic [7:0] pi, input logic [7:0] hd,
                            input logic lh, output logic [7:0] rd);
    bit w;
    w = m_wsel;
    if (m_lh && !lh) m_wsel = ~m_wsel;
    m_lh = lh;
    rd = m_bank[!w][hd];
    m_bank[!w][hd] = 8'hff;
    if (!px[8] && pi[3:0] != 4'hf
`ifdef JT1943_OBJBUF_FIRSTWIN_EN
        && m_bank[w][px[7:0]][3:0] == 4'hf
`endif
       )
      m_bank[w][px[7:0]] = pi;
  endtask

  // Entered and left on a negedge; spans exactly 4 clks with cen6 on the first.
  task automatic slot(input logic [8:0] px, input logic [7:0] pi, input logic [7:0] hd, input logic lh);
    logic [7:0] rd;
    posx = px; pxl_in = pi; hdump = hd; LHBL = lh; cen6 = 1'b1;
    @(negedge clk);
    cen6 = 1'b0;
    check8(tag, obj_pxl, exp_prev);
    model_slot(px, pi, hd, lh, rd);
    exp_prev = rd;
    repeat (3) @(negedge clk);
  endtask

  // Blank falling edge with neither a write nor a meaningful read (address 255 is never drawn).
  task automatic swap();
    slot(9'h100, 8'h00, 8'hff, 1'b1);
    slot(9'h100, 8'h00, 8'hff, 1'b0);
  endtask

  // Counts clks from reset release until busy drops, with a free-running cen6.
  task automatic wait_clr(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      cen6 = (i % 4 == 0);
      @(negedge clk);
      n++;
      if (!busy) break;
    end
    cen6 = 1'b0;
    checks++;
    assert (n == 256) else begin
      errors++;
      $error("FAIL %s busy clks got %0d exp 256", name, n);
    end
  endtask

  initial begin
    logic [8:0] px;
    logic [7:0] pi;

    // Reset state
    repeat (3) @(negedge clk);
    check8("rst_obj_pxl", obj_pxl, 8'hff);
    check1("rst_busy", busy, 1'b1);
    rst_n = 1'b1;
    model_reset();
    wait_clr("clr_sweep");

    // 1: the first line on screen is empty everywhere
    tag = "t1_blank_line";
    for (int i = 0; i < 256; i++) slot(9'h100, 8'h00, 8'(i), 1'b1);

    // 2: one pixel, read back once, then cleared
    tag = "t2_write";
    slot(9'd10, 8'h35, 8'hff, 1'b1);
    swap();
    tag = "t2_read";
    slot(9'h100, 8'h00, 8'd10, 1'b1);
    slot(9'h100, 8'h00, 8'd10, 1'b1);
    tag = "t2_reread";
    slot(9'h100, 8'h00, 8'd0, 1'b1);

    // 3: transparent pixel and off-line posx write nothing
    tag = "t3_nowrite";
    slot(9'd10, 8'h2f, 8'hff, 1'b1);
    slot(9'h10a, 8'h11, 8'hff, 1'b1);
    swap();
    slot(9'h100, 8'h00, 8'd10, 1'b1);
    slot(9'h100, 8'h00, 8'd0, 1'b1);

    // 4: two opaque pixels at one location
    tag = "t4_priority";
    slot(9'd20, 8'h41, 8'hff, 1'b1);
    slot(9'd20, 8'h72, 8'hff, 1'b1);
    swap();
    slot(9'h100, 8'h00, 8'd20, 1'b1);
    slot(9'h100, 8'h00, 8'd0, 1'b1);

    // 5: same-slot write and read at one address use different banks
    tag = "t5_samepos";
    slot(9'd30, 8'h5a, 8'hff, 1'b1);
    swap();
    slot(9'd30, 8'h6b, 8'd30, 1'b1);
    slot(9'h100, 8'h00, 8'd30, 1'b1);
    swap();
    slot(9'h100, 8'h00, 8'd30, 1'b1);
    slot(9'h100, 8'h00, 8'd0, 1'b1);

    // Random lines
    tag = "rand";
    for (int l = 0; l < 20; l++) begin
      for (int s = 0; s < 40; s++) begin
        px = 9'($urandom_range(0, 511));
        if (px[7:0] == 8'hff) px[8] = 1'b1;
        pi = 8'($urandom);
        if ($urandom_range(0, 3) == 0) pi[3:0] = 4'hf;
        slot(px, pi, 8'($urandom), 1'b1);
      end
      swap();
    end

    // 6: reset during phase 2 of a write slot
    tag = "t6_setup";
    slot(9'd40, 8'h56, 8'hff, 1'b1);
    swap();
    slot(9'h100, 8'h00, 8'd40, 1'b1);
    posx = 9'd50; pxl_in = 8'h77; hdump = 8'hff; LHBL = 1'b1; cen6 = 1'b1;
    @(negedge clk);
    cen6 = 1'b0;
    check8("t6_pre_reset", obj_pxl, exp_prev);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check8("t6_rst_obj_pxl", obj_pxl, 8'hff);
    check1("t6_rst_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wait_clr("t6_clr_sweep");
    tag = "t6_blank_bank1";
    for (int i = 0; i < 256; i++) slot(9'h100, 8'h00, 8'(i), 1'b1);
    swap();
    tag = "t6_blank_bank0";
    for (int i = 0; i < 256; i++) slot(9'h100, 8'h00, 8'(i), 1'b1);
    slot(9'h100, 8'h00, 8'd0, 1'b1);
    check1("t6_busy_low", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
